// File: rtl/lcg_stim_gen_if.sv
// ---------------------------------------------------------------------------
// lcg_stim_gen_if
// Valid/ready vector bus between the LCG stimulus source and its consumer.
//   out_data  : OUT_W-bit vector (drives the consumer's in_flat bus)
//   out_valid : out_data holds a complete vector
//   out_ready : consumer accepts; a transfer is out_valid && out_ready
// master modport is the producer side, slave modport the consumer side.
// ---------------------------------------------------------------------------
interface lcg_stim_gen_if #(
  parameter int OUT_W = 138
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/lcg_stim_gen.sv
// ---------------------------------------------------------------------------
// lcg_stim_gen
// Deterministic stimulus source: builds OUT_W-bit vectors from a 32-bit LCG
// (one word per clock) and hands each one over a valid/ready handshake until
// a programmed number of vectors has been transferred.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   start    : launch pulse, honoured only in IDLE or DONE
//   seed     : LCG seed, captured on an accepted start
//   num_vec  : number of vectors to emit, captured on an accepted start
//   out_bus  : vector bus (out_data / out_valid / out_ready)
//   vec_idx  : vectors transferred since the last start
//   busy     : high while filling or presenting a vector
//   done     : high once the programmed count has been transferred
// ---------------------------------------------------------------------------
module lcg_stim_gen #(
  parameter int OUT_W = 138,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          seed,
  input  logic [CNT_W-1:0]     num_vec,
  lcg_stim_gen_if.master       out_bus,
  output logic [CNT_W-1:0]     vec_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int NWORDS = (OUT_W + 31) / 32;
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(NWORDS - 1);
  localparam logic [WIDX_W-1:0] WIDX_ZERO = {WIDX_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
  localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_INC = 32'h0000_3039;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // One LCG step, arithmetic modulo 2^32.
  function automatic logic [31:0] lcg_step(input logic [31:0] s);
    lcg_step = s * LCG_MUL + LCG_INC;
  endfunction

  state_t            state_r, state_next;
  logic [31:0]       lcg_r, lcg_next;
  logic [WIDX_W-1:0] widx_r, widx_next;
  logic [CNT_W-1:0]  vec_idx_r, vec_idx_next;
  logic [CNT_W-1:0]  num_r, num_next;
  logic [OUT_W-1:0]  data_r, data_next;
  logic              valid_r, busy_r, done_r;

  logic [31:0]       lcg_word;
  logic [WIDX_W+4:0] word_shift;
  logic [OUT_W-1:0]  word_mask;
  logic [OUT_W-1:0]  word_bits;
  logic [CNT_W-1:0]  vec_idx_inc;

  assign lcg_word    = lcg_step(lcg_r);
  // Word k lives at bit 32k; shifting an OUT_W-wide mask drops the bits of the
  // last word that would fall above OUT_W, which gives the truncation for free.
  assign word_shift  = {widx_r, 5'b00000};
  assign word_mask   = OUT_W'(32'hFFFF_FFFF) << word_shift;
  assign word_bits   = OUT_W'(lcg_word) << word_shift;
  assign vec_idx_inc = vec_idx_r + CNT_ONE;

  // Next-state and datapath-next logic for the fill/present sequencer.
  always_comb begin
    state_next   = state_r;
    lcg_next     = lcg_r;
    widx_next    = widx_r;
    vec_idx_next = vec_idx_r;
    num_next     = num_r;
    data_next    = data_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lcg_next     = seed;
          num_next     = num_vec;
          vec_idx_next = CNT_ZERO;
          widx_next    = WIDX_ZERO;
          if (num_vec != CNT_ZERO) begin
            state_next = ST_FILL;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          state_next = state_r;
        end
      end

      ST_FILL: begin
        lcg_next  = lcg_word;
        data_next = (data_r & ~word_mask) | word_bits;
        if (widx_r == WIDX_LAST) begin
          widx_next  = WIDX_ZERO;
          state_next = ST_PRESENT;
        end else begin
          widx_next  = widx_r + WIDX_W'(1'b1);
          state_next = ST_FILL;
        end
      end

      ST_PRESENT: begin
        if (out_bus.out_ready) begin
          vec_idx_next = vec_idx_inc;
          widx_next    = WIDX_ZERO;
          if (vec_idx_inc == num_r) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_FILL;
          end
        end else begin
          state_next = ST_PRESENT;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, datapath and status registers; status flags follow the next state
  // so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      lcg_r     <= 32'h0000_0000;
      widx_r    <= WIDX_ZERO;
      vec_idx_r <= CNT_ZERO;
      num_r     <= CNT_ZERO;
      data_r    <= {OUT_W{1'b0}};
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_next;
      lcg_r     <= lcg_next;
      widx_r    <= widx_next;
      vec_idx_r <= vec_idx_next;
      num_r     <= num_next;
      data_r    <= data_next;
      valid_r   <= (state_next == ST_PRESENT);
      busy_r    <= (state_next == ST_FILL) || (state_next == ST_PRESENT);
      done_r    <= (state_next == ST_DONE);
    end
  end

  assign out_bus.out_data  = data_r;
  assign out_bus.out_valid = valid_r;
  assign vec_idx           = vec_idx_r;
  assign busy              = busy_r;
  assign done              = done_r;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_lcg_stim_gen
// Self-checking bench for lcg_stim_gen. Instance A uses OUT_W=138 for the
// table runs, the long randomized cross-check and the corner sequences;
// instance B uses OUT_W=64 for the golden-vector check.
// ---------------------------------------------------------------------------
module tb_lcg_stim_gen;

  localparam int OUT_A = 138;
  localparam int NW_A  = (OUT_A + 31) / 32;
  localparam int OUT_B = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1, a_start = 1'b0;
  logic [31:0] a_seed = 32'h0;
  logic [15:0] a_num = 16'h0;
  logic [15:0] a_vec_idx;
  logic        a_busy, a_done;

  logic        b_rst = 1'b1, b_start = 1'b0;
  logic [31:0] b_seed = 32'h0;
  logic [15:0] b_num = 16'h0;
  logic [15:0] b_vec_idx;
  logic        b_busy, b_done;

  lcg_stim_gen_if #(.OUT_W(OUT_A)) a_bus ();
  lcg_stim_gen_if #(.OUT_W(OUT_B)) b_bus ();

  lcg_stim_gen #(.OUT_W(OUT_A), .CNT_W(16)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .seed(a_seed), .num_vec(a_num),
    .out_bus(a_bus), .vec_idx(a_vec_idx), .busy(a_busy), .done(a_done)
  );

  lcg_stim_gen #(.OUT_W(OUT_B), .CNT_W(16)) u_b (
    .clk(clk), .rst(b_rst), .start(b_start), .seed(b_seed), .num_vec(b_num),
    .out_bus(b_bus), .vec_idx(b_vec_idx), .busy(b_busy), .done(b_done)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] model_s;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: next vector = NW_A successive LCG outputs, low word first,
  // upper bits above OUT_A discarded.
  task automatic gen_vec(output logic [OUT_A-1:0] v);
    logic [NW_A*32-1:0] full;
    for (int k = 0; k < NW_A; k++) begin
      model_s = model_s * 32'h41C64E6D + 32'h00003039;
      full[32*k +: 32] = model_s;
    end
    v = full[OUT_A-1:0];
  endtask

  // Launch a run on instance A and drain it with random backpressure.
  task automatic run_stream(input logic [31:0] s, input int n, input int pct,
                            input bit chk_w0, input logic [31:0] w0,
                            input bit poke, input string tag);
    logic [OUT_A-1:0] ev;
    int got, cyc;
    bit first, prev_valid, prev_xfer;
    model_s = s;
    got = 0; cyc = 0; first = 1'b1; prev_valid = 1'b0; prev_xfer = 1'b0;
    @(negedge clk);
    a_start = 1'b1; a_seed = s; a_num = n[15:0]; a_bus.out_ready = 1'b0;
    @(negedge clk);
    a_start = 1'b0;
    gen_vec(ev);
    while (got < n && cyc < 20000) begin
      if (poke && (cyc == 2 || cyc == 7)) begin
        a_start = 1'b1; a_seed = ~s; a_num = 16'd1;
      end else begin
        a_start = 1'b0;
      end
      if (prev_valid && !prev_xfer) chk({tag, " valid_hold"}, 160'(a_bus.out_valid), 160'(1));
      chk({tag, " vec_idx"}, 160'(a_vec_idx), 160'(got));
      a_bus.out_ready = ($urandom_range(99) < pct);
      prev_valid = a_bus.out_valid;
      prev_xfer  = a_bus.out_valid && a_bus.out_ready;
      if (prev_xfer) begin
        chk({tag, " data"}, 160'(a_bus.out_data), 160'(ev));
        if (first && chk_w0) chk({tag, " word0"}, 160'(a_bus.out_data[31:0]), 160'(w0));
        first = 1'b0;
        got++;
        if (got < n) gen_vec(ev);
      end
      @(negedge clk);
      cyc++;
    end
    a_start = 1'b0;
    a_bus.out_ready = 1'b0;
    chk({tag, " count_or_timeout"}, 160'(got), 160'(n));
    chk({tag, " done"}, 160'(a_done), 160'(1));
    chk({tag, " final_idx"}, 160'(a_vec_idx), 160'(n));
    chk({tag, " valid_after"}, 160'(a_bus.out_valid), 160'(0));
  endtask

  // Wait (bounded) for instance A to present; returns cycles observed.
  task automatic wait_valid_a(input string tag, output int cyc);
    cyc = 1;
    while (!a_bus.out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " valid_seen"}, 160'(a_bus.out_valid), 160'(1));
  endtask

  typedef struct {
    logic [31:0] seed;
    int          n;
    int          pct;
    logic [31:0] w0;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [OUT_A-1:0] ev;
    int cyc;

    tbl[0] = '{seed: 32'h00000000, n: 3, pct: 100, w0: 32'h00003039};
    tbl[1] = '{seed: 32'h00000001, n: 4, pct: 50,  w0: 32'h41C67EA6};
    tbl[2] = '{seed: 32'hFFFFFFFF, n: 2, pct: 30,  w0: 32'hBE39E1CC};
    tbl[3] = '{seed: 32'h00003039, n: 5, pct: 70,  w0: 32'hD3DC167E};

    a_bus.out_ready = 1'b0;
    b_bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;

    // Reset while presenting.
    @(negedge clk);
    a_start = 1'b1; a_seed = 32'h1234; a_num = 16'd4;
    @(negedge clk);
    a_start = 1'b0;
    wait_valid_a("rst_pre", cyc);
    a_rst = 1'b1;
    @(negedge clk);
    chk("rst valid", 160'(a_bus.out_valid), 160'(0));
    chk("rst data", 160'(a_bus.out_data), 160'(0));
    chk("rst vec_idx", 160'(a_vec_idx), 160'(0));
    chk("rst busy", 160'(a_busy), 160'(0));
    chk("rst done", 160'(a_done), 160'(0));
    repeat (2) @(negedge clk);
    a_rst = 1'b0;

    // Golden vector on the 64-bit instance.
    @(negedge clk);
    b_start = 1'b1; b_seed = 32'h0; b_num = 16'd1; b_bus.out_ready = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 1;
    while (!b_bus.out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("gold latency", 160'(cyc), 160'(3));
    chk("gold data", 160'(b_bus.out_data), 160'(64'hD3DC167E_00003039));
    @(negedge clk);
    chk("gold done", 160'(b_done), 160'(1));
    chk("gold vec_idx", 160'(b_vec_idx), 160'(1));
    chk("gold valid_off", 160'(b_bus.out_valid), 160'(0));

    // num_vec = 0 goes straight to DONE.
    @(negedge clk);
    a_start = 1'b1; a_seed = 32'hABCD; a_num = 16'd0;
    @(negedge clk);
    a_start = 1'b0;
    chk("zero done", 160'(a_done), 160'(1));
    chk("zero busy", 160'(a_busy), 160'(0));
    chk("zero vec_idx", 160'(a_vec_idx), 160'(0));
    for (int i = 0; i < 4; i++) begin
      chk("zero valid", 160'(a_bus.out_valid), 160'(0));
      @(negedge clk);
    end

    // Table runs, launched back-to-back from DONE (entry 0 is the seed-0 restart).
    for (int i = 0; i < 4; i++) begin
      run_stream(tbl[i].seed, tbl[i].n, tbl[i].pct, 1'b1, tbl[i].w0, 1'b0, $sformatf("tbl%0d", i));
    end

    // Long randomized cross-check.
    run_stream(32'd784456416, 151, 60, 1'b0, 32'h0, 1'b0, "xchk");

    // Backpressure: stall 10 cycles, then one transfer, then the gap.
    model_s = 32'h5A5A_0F0F;
    gen_vec(ev);
    @(negedge clk);
    a_start = 1'b1; a_seed = 32'h5A5A_0F0F; a_num = 16'd2; a_bus.out_ready = 1'b0;
    @(negedge clk);
    a_start = 1'b0;
    wait_valid_a("bp", cyc);
    chk("bp latency", 160'(cyc), 160'(NW_A + 1));
    for (int i = 0; i < 10; i++) begin
      chk("bp hold_valid", 160'(a_bus.out_valid), 160'(1));
      chk("bp hold_data", 160'(a_bus.out_data), 160'(ev));
      chk("bp hold_idx", 160'(a_vec_idx), 160'(0));
      @(negedge clk);
    end
    a_bus.out_ready = 1'b1;
    @(negedge clk);
    a_bus.out_ready = 1'b0;
    chk("bp idx1", 160'(a_vec_idx), 160'(1));
    chk("bp gap_valid", 160'(a_bus.out_valid), 160'(0));
    wait_valid_a("bp2", cyc);
    chk("bp gap_len", 160'(cyc), 160'(NW_A + 1));
    gen_vec(ev);
    chk("bp vec2", 160'(a_bus.out_data), 160'(ev));
    a_bus.out_ready = 1'b1;
    @(negedge clk);
    a_bus.out_ready = 1'b0;
    chk("bp done", 160'(a_done), 160'(1));
    chk("bp idx2", 160'(a_vec_idx), 160'(2));

    // start pulses while busy are ignored.
    run_stream(32'hC0FF_EE11, 2, 40, 1'b0, 32'h0, 1'b1, "busy_start");

    // Reset after 2 of 5 fill words, then relaunch with the same seed.
    @(negedge clk);
    a_start = 1'b1; a_seed = 32'h0BAD_F00D; a_num = 16'd1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midfill busy_before", 160'(a_busy), 160'(1));
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    chk("midfill busy", 160'(a_busy), 160'(0));
    chk("midfill done", 160'(a_done), 160'(0));
    chk("midfill data", 160'(a_bus.out_data), 160'(0));
    chk("midfill valid", 160'(a_bus.out_valid), 160'(0));
    run_stream(32'h0BAD_F00D, 1, 100, 1'b0, 32'h0, 1'b0, "midfill_rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcg_stim_gen.md
Name: lcg_stim_gen

Overview:
- Synthesizable stimulus source sitting directly upstream of a DUT's `in_flat` bus in the fuzz harness.
- Produces the same deterministic vector stream as the bench-side generator, so RTL-driven and bench-driven runs match bit-for-bit.
- Vectors are built from a 32-bit LCG, one word per clock.
- Each vector is delivered over a valid/ready handshake; the block stops after a programmed vector count.

Parameters:
- OUT_W, 138, vector width in bits (≥1).
- NWORDS, ceil(OUT_W/32), LCG words per vector (derived localparam, not overridable).
- CNT_W, 16, width of the vector counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle launch pulse; sampled only in IDLE or DONE.
- seed  in  32  LCG seed; captured on accepted start.
- num_vec  in  CNT_W  vectors to emit; captured on accepted start.
- out_data  out  OUT_W  current vector (drives DUT in_flat).
- out_valid  out  1  out_data holds a complete vector.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- vec_idx  out  CNT_W  count of vectors transferred since start.
- busy  out  1  high in FILL or PRESENT.
- done  out  1  high in DONE.

Behaviour:
- LCG step: s_next = (s * 32'h41C64E6D + 32'h3039) mod 2^32. Step 0 uses the captured seed.
- Word k (0-based) of a vector is the k-th successive LCG output. It is placed at out_data[32k+31:32k].
- The last word is truncated to its low (OUT_W - 32*(NWORDS-1)) bits.
- The LCG state carries across vectors; it is never reseeded mid-run.
- FSM states: IDLE, FILL, PRESENT, DONE.
- IDLE:
  - start with num_vec≠0 → capture seed/num_vec; clear vec_idx and word index → FILL.
  - start with num_vec=0 → DONE.
- FILL:
  - One LCG step per cycle; the result is written into out_data word[widx]; widx increments.
  - After writing word NWORDS-1 → PRESENT.
  - FILL lasts exactly NWORDS cycles.
- PRESENT:
  - out_valid=1; out_data is held stable until transfer.
  - On transfer, vec_idx increments.
  - If the new vec_idx equals num_vec → DONE; otherwise → FILL, with widx cleared.
- DONE:
  - done=1, out_valid=0; out_data and vec_idx hold.
  - start relaunches exactly as from IDLE.
- Start latency: first out_valid rises NWORDS+1 cycles after the start-sampling edge (FILL occupies NWORDS cycles).
- Inter-vector gap: NWORDS cycles with out_valid=0 after each transfer (no overlap of FILL and PRESENT).
- start while busy is ignored; seed and num_vec changes while busy have no effect.
- out_ready while out_valid=0 has no effect. out_valid never drops without a transfer, except on rst.
- out_data bits above OUT_W do not exist; during FILL, partially written out_data is visible but not valid.
- rst (any state, including mid-FILL or mid-PRESENT) on the next edge forces:
  - state IDLE
  - out_data=0, out_valid=0, vec_idx=0, busy=0, done=0
  - internal LCG state=0, widx=0
- rst has priority over start in the same cycle.
- Counter width: num_vec up to 2^CNT_W-1; vec_idx never wraps within a run.

Test Plan:
- Reset values: assert rst for 3 cycles mid-PRESENT → next edge out_valid=0, out_data=0, vec_idx=0, busy=0, done=0.
- Golden vector, OUT_W=64, seed=0, num_vec=1, out_ready=1:
  - out_valid rises 3 cycles after start.
  - out_data=64'hD3DC167E_00003039.
  - DONE follows on the next cycle with vec_idx=1.
- Cross-check stream, OUT_W=138, seed=784456416, num_vec=151:
  - Every transferred vector equals the bench LCG model (5 steps per vector, top word masked to 10 bits).
  - done asserts with vec_idx=151.
- Backpressure: hold out_ready=0 for 10 cycles in PRESENT → out_valid stays 1, out_data unchanged, vec_idx unchanged, no LCG advance; release → single transfer.
- Edge cases:
  - num_vec=0 → DONE one cycle after start, out_valid never asserts.
  - start pulsed while busy → ignored.
  - start in DONE with seed=0 → stream restarts at 0x00003039.
- Reset mid-FILL (after 2 of 5 words) → IDLE; a subsequent start with the same seed reproduces the original first vector exactly.
